riscv_trace_buffer: RTL and testbench
=====================================

# riscv_trace_buffer

Synthesizable commit-trace capture unit for the RISC-V cores. It samples the retire/commit signals of the monocycle core every clock and classifies each retired instruction (register write, store, branch taken/not-taken, jump, none). It time-stamps each record and buffers it in a parametrised FIFO, which is drained over a valid/ready port. It sits beside the core top level and replaces printf-style tracing with hardware records usable on silicon, FPGA or in simulation.

## Interface
- XLEN, 32, datapath/address width
- DEPTH, 16, FIFO entries; power of two, ≥2
- CNT_W, 32, width of cycle, retired and drop counters
- MODE, 0, full policy: 0 = STREAM (drop new), 1 = STOP (freeze capture), 2 = RING (overwrite oldest)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- enable  in  1  capture and cycle counting enabled
- clear  in  1  synchronous flush of FIFO, counters, sticky flags; wins over all other activity
- kind_mask  in  6  bit k = 1 captures kind k
- commit_valid  in  1  an instruction retires this cycle
- commit_pc, commit_pc_next  in  XLEN  PC of retiring instruction, PC of the next instruction
- commit_instr  in  32  instruction word
- commit_reg_write, commit_mem_write, commit_branch, commit_jump  in  1  control of retiring instruction
- commit_rd  in  5  destination register
- commit_result  in  XLEN  register write-back value
- commit_mem_addr, commit_mem_data  in  XLEN  store address/data
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_cycle  out  CNT_W  cycle stamp
- out_pc  out  XLEN; out_instr  out  32; out_kind  out  3; out_rd  out  5
- out_data, out_addr  out  XLEN  payload
- level  out  $clog2(DEPTH)+1  entries held
- full, empty, stopped, overflow  out  1  status; overflow sticky
- cycle_count, retired_count, drop_count  out  CNT_W  counters

## Operation
- Kind, first match wins: 1 REG (reg_write && rd≠0); 2 MEM (mem_write); 3 BR_T (branch && pc_next≠pc+4); 4 BR_N (branch); 5 JMP (jump); 0 NONE.
- Payload: REG data=result; MEM data=mem_data, addr=mem_addr; BR_T/BR_N/JMP data=pc_next; other fields 0. out_rd = rd for REG, else 0. pc+4 wraps modulo 2^XLEN.
- Capture condition: enable && commit_valid && kind_mask[kind] && !stopped.
- Counters:
  - cycle_count increments each enabled cycle.
  - retired_count increments on enable && commit_valid, whether masked or not.
  - Stamp = cycle_count value before increment; first enabled cycle after reset stamps 0.
- Push when captured: always succeeds if not full, or if full && out_ready popping the same cycle.
- Full, no pop:
  - STREAM: record discarded, drop_count++, overflow set.
  - STOP: record discarded, drop_count++, overflow and stopped set; stopped blocks further capture until clear/reset; draining continues.
  - RING: oldest entry discarded and new one written, level stays DEPTH, drop_count++, overflow set.
- drop_count saturates at all-ones; cycle_count and retired_count wrap.
- Pop on out_valid && out_ready. Output fields are constant while out_valid && !out_ready, except in RING overwrite, where the head advances to the next-oldest record.

## Timing
- Reset values:
  - out_valid=0, empty=1, full=0, level=0, stopped=0, overflow=0.
  - All counters 0.
  - All out_* data fields 0.
- Latency: a commit sampled at edge N is visible on out_* after edge N (out_valid in cycle N+1); no combinational path from commit_* to out_*.
- full/empty/level/status reflect state after the last edge, registered.
- Simultaneous push/pop with level 1: the popped record leaves and the new record becomes the head next cycle; out_valid stays 1.
- clear asserted: next cycle empty, counters 0, stopped/overflow 0; a commit in the clear cycle is not captured.
- reset mid-drain: out_valid drops immediately (asynchronous); no partial record survives.

## Test plan
- Reset, enable=1, mask=6'h3F; retire addi x1 (rd=1, result=5) at pc 0 -> one cycle later out_kind=1, out_rd=1, out_data=5, out_cycle=0, retired_count=1.
- Branch at pc 0x10 with pc_next=0x08, then at pc 0x14 with pc_next=0x18 -> records kind 3 (data 0x08), then kind 4 (data 0x18).
- STREAM, DEPTH=4, out_ready=0, six REG commits -> level=4, drop_count=2, overflow=1; drain yields first four in order.
- RING, DEPTH=4, six commits with results 1..6 -> drain yields 3,4,5,6; drop_count=2.
- STOP, DEPTH=4, five commits then drain -> stopped=1, exactly four records; further commits ignored until clear, then capture resumes with stamp 0.
- mask=6'b000100 (MEM only) on mixed stream of 3 REG + 2 stores -> 2 records of kind 2 with correct addr/data; retired_count=5, drop_count=0.

Source files
------------

// File: rtl/riscv_trace_buffer.sv
// ============================================================================
// riscv_trace_buffer : commit-trace capture with time-stamped record FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [5:0]                 kind_mask,
    input  logic                       commit_valid,
    input  logic [XLEN-1:0]            commit_pc,
    input  logic [XLEN-1:0]            commit_pc_next,
    input  logic [31:0]                commit_instr,
    input  logic                       commit_reg_write,
    input  logic                       commit_mem_write,
    input  logic                       commit_branch,
    input  logic                       commit_jump,
    input  logic [4:0]                 commit_rd,
    input  logic [XLEN-1:0]            commit_result,
    input  logic [XLEN-1:0]            commit_mem_addr,
    input  logic [XLEN-1:0]            commit_mem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           out_cycle,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [2:0]                 out_kind,
    output logic [4:0]                 out_rd,
    output logic [XLEN-1:0]            out_data,
    output logic [XLEN-1:0]            out_addr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       stopped,
    output logic                       overflow,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           retired_count,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = CNT_W + XLEN + 32 + 3 + 5 + XLEN + XLEN;

    localparam int MODE_STREAM = 0;
    localparam int MODE_STOP   = 1;
    localparam int MODE_RING   = 2;

    localparam logic [2:0] KIND_NONE = 3'd0;
    localparam logic [2:0] KIND_REG  = 3'd1;
    localparam logic [2:0] KIND_MEM  = 3'd2;
    localparam logic [2:0] KIND_BR_T = 3'd3;
    localparam logic [2:0] KIND_BR_N = 3'd4;
    localparam logic [2:0] KIND_JMP  = 3'd5;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [XLEN-1:0]  pc_plus4;
    logic [2:0]       cls_kind;
    logic [4:0]       cls_rd;
    logic [XLEN-1:0]  cls_data;
    logic [XLEN-1:0]  cls_addr;

    logic             do_cap;
    logic             do_pop;
    logic             do_push;
    logic             full_drop;
    logic             ring_ow;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] lvl;
    logic             stop_flag;
    logic             ovf_flag;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] drp_cnt;

    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] head;
    logic [REC_W-1:0] new_rec;

    // First match wins; a reg write to x0 falls through to the next class.
    always_comb begin
        pc_plus4 = commit_pc + XLEN'(4);
        cls_kind = KIND_NONE;
        cls_rd   = 5'd0;
        cls_data = '0;
        cls_addr = '0;
        if (commit_reg_write && (commit_rd != 5'd0)) begin
            cls_kind = KIND_REG;
            cls_rd   = commit_rd;
            cls_data = commit_result;
        end else if (commit_mem_write) begin
            cls_kind = KIND_MEM;
            cls_data = commit_mem_data;
            cls_addr = commit_mem_addr;
        end else if (commit_branch && (commit_pc_next != pc_plus4)) begin
            cls_kind = KIND_BR_T;
            cls_data = commit_pc_next;
        end else if (commit_branch) begin
            cls_kind = KIND_BR_N;
            cls_data = commit_pc_next;
        end else if (commit_jump) begin
            cls_kind = KIND_JMP;
            cls_data = commit_pc_next;
        end
    end

    assign new_rec = {cyc_cnt, commit_pc, commit_instr, cls_kind, cls_rd, cls_data, cls_addr};

    assign empty     = (lvl == '0);
    assign full      = (lvl == LVL_FULL);
    assign do_cap    = enable && commit_valid && kind_mask[cls_kind] && !stop_flag;
    assign do_pop    = !empty && out_ready;
    assign full_drop = do_cap && full && !do_pop;
    assign ring_ow   = full_drop && (MODE == MODE_RING);
    assign do_push   = (do_cap && (!full || do_pop)) || ring_ow;

    // Storage is not reset; the output gating below hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lvl       <= '0;
            stop_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            drp_cnt   <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lvl       <= '0;
            stop_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            drp_cnt   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || ring_ow) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop && !ring_ow) begin
                lvl <= lvl + 1'b1;
            end else if (do_pop && !do_push) begin
                lvl <= lvl - 1'b1;
            end
            if (full_drop) begin
                ovf_flag <= 1'b1;
                if (drp_cnt != '1) begin
                    drp_cnt <= drp_cnt + 1'b1;
                end
                if (MODE == MODE_STOP) begin
                    stop_flag <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else if (clear) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else if (enable) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (commit_valid) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_valid = !empty;
    assign {out_cycle, out_pc, out_instr, out_kind, out_rd, out_data, out_addr} = head;

    assign level         = lvl;
    assign stopped       = stop_flag;
    assign overflow      = ovf_flag;
    assign cycle_count   = cyc_cnt;
    assign retired_count = ret_cnt;
    assign drop_count    = drp_cnt;

endmodule

`default_nettype wire

// File: tb/tb_riscv_trace_buffer.sv
// ============================================================================
// tb_riscv_trace_buffer : directed bench over STREAM, STOP and RING instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_trace_buffer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [5:0]  kind_mask;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_pc_next;
    logic [31:0] commit_instr;
    logic        commit_reg_write;
    logic        commit_mem_write;
    logic        commit_branch;
    logic        commit_jump;
    logic [4:0]  commit_rd;
    logic [31:0] commit_result;
    logic [31:0] commit_mem_addr;
    logic [31:0] commit_mem_data;
    logic [2:0]  ready;

    logic        vld    [3];
    logic [31:0] cyco   [3];
    logic [31:0] pco    [3];
    logic [31:0] instro [3];
    logic [2:0]  kind   [3];
    logic [4:0]  rdo    [3];
    logic [31:0] data   [3];
    logic [31:0] addr   [3];
    logic [2:0]  lvl    [3];
    logic        fullf  [3];
    logic        emptyf [3];
    logic        stopf  [3];
    logic        ovff   [3];
    logic [31:0] cycc   [3];
    logic [31:0] retc   [3];
    logic [31:0] dropc  [3];

    int checks = 0;
    int errors = 0;

    // Instance m runs full-policy MODE=m: 0 STREAM, 1 STOP, 2 RING.
    for (genvar m = 0; m < 3; m++) begin : g_dut
        riscv_trace_buffer #(
            .XLEN(32), .DEPTH(4), .CNT_W(32), .MODE(m)
        ) dut (
            .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
            .kind_mask(kind_mask), .commit_valid(commit_valid),
            .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
            .commit_instr(commit_instr), .commit_reg_write(commit_reg_write),
            .commit_mem_write(commit_mem_write), .commit_branch(commit_branch),
            .commit_jump(commit_jump), .commit_rd(commit_rd),
            .commit_result(commit_result), .commit_mem_addr(commit_mem_addr),
            .commit_mem_data(commit_mem_data),
            .out_valid(vld[m]), .out_ready(ready[m]), .out_cycle(cyco[m]),
            .out_pc(pco[m]), .out_instr(instro[m]), .out_kind(kind[m]),
            .out_rd(rdo[m]), .out_data(data[m]), .out_addr(addr[m]),
            .level(lvl[m]), .full(fullf[m]), .empty(emptyf[m]),
            .stopped(stopf[m]), .overflow(ovff[m]),
            .cycle_count(cycc[m]), .retired_count(retc[m]), .drop_count(dropc[m])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic rw, input logic mw, input logic br, input logic jp,
                          input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pcn,
                          input logic [31:0] res, input logic [31:0] maddr, input logic [31:0] mdata);
        commit_valid     = 1'b1;
        commit_reg_write = rw;
        commit_mem_write = mw;
        commit_branch    = br;
        commit_jump      = jp;
        commit_rd        = rd;
        commit_pc        = pc;
        commit_pc_next   = pcn;
        commit_result    = res;
        commit_mem_addr  = maddr;
        commit_mem_data  = mdata;
        step();
        commit_valid     = 1'b0;
        commit_reg_write = 1'b0;
        commit_mem_write = 1'b0;
        commit_branch    = 1'b0;
        commit_jump      = 1'b0;
    endtask

    task automatic reg_commit(input logic [31:0] res);
        commit(1, 0, 0, 0, 5'd2, 32'h40, 32'h44, res, 32'h0, 32'h0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_s [4];
        logic [31:0] exp_r [4];
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; kind_mask = 6'h3F; ready = 3'b000;
        commit_valid = 1'b0; commit_pc = '0; commit_pc_next = '0; commit_instr = 32'h00000013;
        commit_reg_write = 1'b0; commit_mem_write = 1'b0; commit_branch = 1'b0;
        commit_jump = 1'b0; commit_rd = '0; commit_result = '0;
        commit_mem_addr = '0; commit_mem_data = '0;

        #12;
        check("rst_valid", 64'(vld[0]), 64'd0);
        check("rst_empty", 64'(emptyf[0]), 64'd1);
        check("rst_full", 64'(fullf[0]), 64'd0);
        check("rst_level", 64'(lvl[0]), 64'd0);
        check("rst_flags", 64'({stopf[2], ovff[0]}), 64'd0);
        check("rst_counters", 64'(cycc[0] | retc[0] | dropc[0]), 64'd0);
        check("rst_data", 64'(data[0] | pco[0] | cyco[0]), 64'd0);

        rst_n = 1'b1;
        enable = 1'b1;
        commit_instr = 32'h00500093;
        commit(1, 0, 0, 0, 5'd1, 32'h0, 32'h4, 32'd5, 32'h0, 32'h0);
        commit_instr = 32'h00000013;
        check("addi_valid", 64'(vld[0]), 64'd1);
        check("addi_kind", 64'(kind[0]), 64'd1);
        check("addi_rd", 64'(rdo[0]), 64'd1);
        check("addi_data", 64'(data[0]), 64'd5);
        check("addi_cycle", 64'(cyco[0]), 64'd0);
        check("addi_instr", 64'(instro[0]), 64'h00500093);
        check("addi_retired", 64'(retc[0]), 64'd1);
        check("addi_cyccnt", 64'(cycc[0]), 64'd1);

        pulse_clear();
        check("clr_level", 64'(lvl[0]), 64'd0);
        check("clr_cyccnt", 64'(cycc[0]), 64'd0);
        check("clr_retired", 64'(retc[0]), 64'd0);

        // Branches, jump and a branch whose pc+4 wraps to zero.
        commit(0, 0, 1, 0, 5'd0, 32'h10, 32'h08, 32'h0, 32'h0, 32'h0);
        commit(0, 0, 1, 0, 5'd0, 32'h14, 32'h18, 32'h0, 32'h0, 32'h0);
        check("brt_kind", 64'(kind[0]), 64'd3);
        check("brt_data", 64'(data[0]), 64'h08);
        check("brt_pc", 64'(pco[0]), 64'h10);
        check("brt_cycle", 64'(cyco[0]), 64'd0);
        check("br_level", 64'(lvl[0]), 64'd2);
        ready = 3'b001; step(); ready = 3'b000;
        check("brn_kind", 64'(kind[0]), 64'd4);
        check("brn_data", 64'(data[0]), 64'h18);
        check("brn_cycle", 64'(cyco[0]), 64'd1);
        step();
        check("hold_kind", 64'(kind[0]), 64'd4);
        commit(1, 0, 0, 1, 5'd0, 32'h20, 32'h100, 32'h0, 32'h0, 32'h0);
        commit(0, 0, 1, 0, 5'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0);
        check("jmp_level", 64'(lvl[0]), 64'd3);
        ready = 3'b001; step(); ready = 3'b000;
        check("jmp_kind", 64'(kind[0]), 64'd5);
        check("jmp_data", 64'(data[0]), 64'h100);
        check("jmp_rd", 64'(rdo[0]), 64'd0);
        ready = 3'b001; step(); ready = 3'b000;
        check("wrap_kind", 64'(kind[0]), 64'd4);
        check("wrap_pc", 64'(pco[0]), 64'hFFFF_FFFC);

        pulse_clear();
        // Six commits into a 4-deep FIFO with no consumer.
        for (int i = 1; i <= 6; i++) reg_commit(32'(i));
        check("strm_level", 64'(lvl[0]), 64'd4);
        check("strm_full", 64'(fullf[0]), 64'd1);
        check("strm_drop", 64'(dropc[0]), 64'd2);
        check("strm_ovf", 64'(ovff[0]), 64'd1);
        check("strm_stop", 64'(stopf[0]), 64'd0);
        check("ring_level", 64'(lvl[2]), 64'd4);
        check("ring_drop", 64'(dropc[2]), 64'd2);
        check("ring_ovf", 64'(ovff[2]), 64'd1);
        check("stop_drop", 64'(dropc[1]), 64'd1);
        check("stop_flag", 64'(stopf[1]), 64'd1);
        check("stop_level", 64'(lvl[1]), 64'd4);
        exp_s = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_r = '{32'd3, 32'd4, 32'd5, 32'd6};
        ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("strm_drain%0d", i), 64'(data[0]), 64'(exp_s[i]));
            check($sformatf("stop_drain%0d", i), 64'(data[1]), 64'(exp_s[i]));
            check($sformatf("ring_drain%0d", i), 64'(data[2]), 64'(exp_r[i]));
            step();
        end
        ready = 3'b000;
        check("drained_valid", 64'({vld[0], vld[1], vld[2]}), 64'd0);
        check("stop_held", 64'(stopf[1]), 64'd1);
        reg_commit(32'd9);
        check("stopped_ignore", 64'(lvl[1]), 64'd0);
        check("stream_take", 64'(lvl[0]), 64'd1);
        check("stopped_nodrop", 64'(dropc[1]), 64'd1);

        pulse_clear();
        check("clr_stop", 64'({stopf[1], ovff[1]}), 64'd0);
        check("clr_drop", 64'(dropc[1]), 64'd0);
        reg_commit(32'd7);
        check("resume_cycle", 64'(cyco[1]), 64'd0);
        check("resume_data", 64'(data[1]), 64'd7);
        // Level-1 push with simultaneous pop: new record becomes head.
        ready = 3'b111;
        reg_commit(32'd8);
        ready = 3'b000;
        check("pp1_valid", 64'(vld[1]), 64'd1);
        check("pp1_level", 64'(lvl[1]), 64'd1);
        check("pp1_data", 64'(data[1]), 64'd8);
        check("pp1_cycle", 64'(cyco[1]), 64'd1);

        pulse_clear();
        for (int i = 10; i <= 13; i++) reg_commit(32'(i));
        ready = 3'b001;
        reg_commit(32'd14);
        ready = 3'b000;
        check("fullpp_level", 64'(lvl[0]), 64'd4);
        check("fullpp_drop", 64'(dropc[0]), 64'd0);
        check("fullpp_head", 64'(data[0]), 64'd11);
        check("ringow_head", 64'(data[2]), 64'd11);
        check("ringow_drop", 64'(dropc[2]), 64'd1);

        pulse_clear();
        kind_mask = 6'b000100;
        reg_commit(32'd1);
        commit(0, 1, 0, 0, 5'd0, 32'h50, 32'h54, 32'h0, 32'h100, 32'hAA);
        reg_commit(32'd2);
        commit(0, 1, 0, 0, 5'd0, 32'h58, 32'h5C, 32'h0, 32'h104, 32'hBB);
        reg_commit(32'd3);
        check("mask_retired", 64'(retc[0]), 64'd5);
        check("mask_level", 64'(lvl[0]), 64'd2);
        check("mask_drop", 64'(dropc[0]), 64'd0);
        check("mem0_kind", 64'(kind[0]), 64'd2);
        check("mem0_addr", 64'(addr[0]), 64'h100);
        check("mem0_data", 64'(data[0]), 64'hAA);
        ready = 3'b001; step(); ready = 3'b000;
        check("mem1_addr", 64'(addr[0]), 64'h104);
        check("mem1_data", 64'(data[0]), 64'hBB);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(vld[0]), 64'd0);
        check("arst_level", 64'(lvl[0]), 64'd0);
        check("arst_data", 64'(data[0] | addr[0]), 64'd0);
        #3;
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
